// File: rtl/blink_pkg.sv
// rtl/blink_pkg.sv - shared types and constants for the LED pattern sequencer
package blink_pkg;
  localparam int LED_W = 8;
  localparam int DUR_W = 8;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // One pattern entry: LED mask shown for dur ticks; dur == 0 terminates the pattern.
  typedef struct packed {
    logic [LED_W-1:0] mask;
    logic [DUR_W-1:0] dur;
  } step_t;
endpackage

// File: rtl/blink_scheduler_if.sv
// rtl/blink_scheduler_if.sv - table programming, playback control and LED status bundle
interface blink_scheduler_if #(
  parameter int STEPS = 8
);
  import blink_pkg::*;
  localparam int AW = $clog2(STEPS);

  logic             cfg_we;
  logic [AW-1:0]    cfg_addr;
  logic [LED_W-1:0] cfg_mask;
  logic [DUR_W-1:0] cfg_dur;
  logic             cfg_ready;
  logic             start;
  logic             stop;
  logic             loop_en;
  logic [LED_W-1:0] led;
  logic             busy;
  logic             done;
  logic [AW-1:0]    step_idx;
  logic             tick;

  modport master (
    output cfg_we, cfg_addr, cfg_mask, cfg_dur, start, stop, loop_en,
    input  cfg_ready, led, busy, done, step_idx, tick
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_mask, cfg_dur, start, stop, loop_en,
    output cfg_ready, led, busy, done, step_idx, tick
  );
endinterface

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - free-running 0..PRESCALE-1 counter with a one-cycle tick on the last count
module tick_prescaler #(
  parameter int PRESCALE = 1000,
  parameter int PS_W     = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en || cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + PS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == LAST);
endmodule

// File: rtl/blink_scheduler.sv
// rtl/blink_scheduler.sv - replays a programmable {mask, duration} table onto the LED bank
module blink_scheduler
  import blink_pkg::*;
#(
  parameter int STEPS    = 8,
  parameter int PRESCALE = 1000,
  parameter int PS_W     = 16,
  localparam int AW      = $clog2(STEPS)
) (
  input logic              clk,
  input logic              rst,
  blink_scheduler_if.slave bus
);
  step_t            table_q [STEPS];
  state_e           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [DUR_W-1:0] remain_q, remain_d;
  logic [LED_W-1:0] led_q, led_d;

  logic          tick;
  logic          wr_en;
  step_t         entry0;
  step_t         nxt_entry;
  logic [AW-1:0] nxt;
  logic          last_step;

  tick_prescaler #(.PRESCALE(PRESCALE), .PS_W(PS_W)) u_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (state_q == RUN),
    .tick(tick)
  );

  assign wr_en = bus.cfg_we && (state_q != RUN);

  // A same-cycle write to entry 0 must be what the starting run sees.
  always_comb begin
    entry0 = table_q[0];
    if (wr_en && bus.cfg_addr == '0) begin
      entry0.mask = bus.cfg_mask;
      entry0.dur  = bus.cfg_dur;
    end
  end

  assign nxt       = idx_q + AW'(1);
  assign nxt_entry = table_q[nxt];
  assign last_step = (idx_q == AW'(STEPS - 1)) || (nxt_entry.dur == '0);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    remain_d = remain_q;
    led_d    = led_q;
    case (state_q)
      IDLE: begin
        led_d = '0;
        if (bus.start && !bus.stop) begin
          if (entry0.dur != '0) begin
            state_d  = RUN;
            idx_d    = '0;
            remain_d = entry0.dur;
            led_d    = entry0.mask;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d  = IDLE;
          idx_d    = '0;
          remain_d = '0;
          led_d    = '0;
        end else if (tick) begin
          if (remain_q > DUR_W'(1)) begin
            remain_d = remain_q - DUR_W'(1);
          end else if (!last_step) begin
            idx_d    = nxt;
            remain_d = nxt_entry.dur;
            led_d    = nxt_entry.mask;
          end else if (bus.loop_en) begin
            idx_d    = '0;
            remain_d = table_q[0].dur;
            led_d    = table_q[0].mask;
          end else begin
            state_d  = DONE;
            remain_d = '0;
            led_d    = '0;
          end
        end
      end
      DONE: begin
        state_d  = IDLE;
        idx_d    = '0;
        remain_d = '0;
        led_d    = '0;
      end
      default: begin
        state_d  = IDLE;
        idx_d    = '0;
        remain_d = '0;
        led_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      remain_q <= '0;
      led_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      remain_q <= remain_d;
      led_q    <= led_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STEPS; i++) begin
        table_q[i] <= '0;
      end
    end else if (wr_en) begin
      table_q[bus.cfg_addr] <= {bus.cfg_mask, bus.cfg_dur};
    end
  end

  assign bus.led       = led_q;
  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.cfg_ready = (state_q != RUN);
  assign bus.step_idx  = idx_q;
  assign bus.tick      = tick;
endmodule

// File: tb/tb_blink_scheduler.sv
// tb/tb_blink_scheduler.sv - self-checking bench for blink_scheduler against a cycle-list model
module tb_blink_scheduler;
  import blink_pkg::*;

  localparam int STEPS = 8;
  localparam int PS    = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  blink_scheduler_if #(.STEPS(STEPS)) bus();

  blink_scheduler #(.STEPS(STEPS), .PRESCALE(PS), .PS_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] m_mask [STEPS];
  logic [7:0] m_dur  [STEPS];

  typedef struct {
    logic [7:0] led;
    int         idx;
    bit         tk;
  } exp_t;
  exp_t q[$];

  // Expected RUN cycles: each live step shows its mask for dur*PS cycles, ticks every PS-th cycle.
  function automatic void expand();
    int n;
    n = 0;
    q.delete();
    for (int i = 0; i < STEPS; i++) begin
      if (m_dur[i] == 0) break;
      for (int c = 0; c < int'(m_dur[i]) * PS; c++) begin
        q.push_back('{led: m_mask[i], idx: i, tk: ((n % PS) == PS - 1)});
        n++;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [7:0] m, input logic [7:0] d);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 3'(a);
    bus.cfg_mask = m;
    bus.cfg_dur  = d;
    cyc();
    bus.cfg_we   = 1'b0;
    m_mask[a]    = m;
    m_dur[a]     = d;
  endtask

  task automatic launch();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic check_run(input string tag, input int from, input int upto);
    for (int k = from; k < upto; k++) begin
      chk({tag, "_led"},  32'(bus.led),      32'(q[k].led));
      chk({tag, "_idx"},  32'(bus.step_idx), 32'(q[k].idx));
      chk({tag, "_busy"}, 32'(bus.busy),     32'd1);
      chk({tag, "_rdy"},  32'(bus.cfg_ready), 32'd0);
      chk({tag, "_done"}, 32'(bus.done),     32'd0);
      chk({tag, "_tick"}, 32'(bus.tick),     32'(q[k].tk));
      cyc();
    end
  endtask

  task automatic check_done(input string tag);
    chk({tag, "_done1"}, 32'(bus.done),      32'd1);
    chk({tag, "_dled"},  32'(bus.led),       32'd0);
    chk({tag, "_dbusy"}, 32'(bus.busy),      32'd0);
    chk({tag, "_drdy"},  32'(bus.cfg_ready), 32'd1);
    cyc();
    chk({tag, "_done0"}, 32'(bus.done),      32'd0);
    chk({tag, "_iled"},  32'(bus.led),       32'd0);
    chk({tag, "_ibusy"}, 32'(bus.busy),      32'd0);
  endtask

  initial begin
    int n;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_mask = '0; bus.cfg_dur = '0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.loop_en = 1'b0;
    for (int i = 0; i < STEPS; i++) begin m_mask[i] = '0; m_dur[i] = '0; end
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_led",  32'(bus.led),      32'd0);
    chk("rst_busy", 32'(bus.busy),     32'd0);
    chk("rst_done", 32'(bus.done),     32'd0);
    chk("rst_idx",  32'(bus.step_idx), 32'd0);
    chk("rst_tick", 32'(bus.tick),     32'd0);
    chk("rst_rdy",  32'(bus.cfg_ready), 32'd1);

    expand();
    launch();
    check_done("empty");

    wr(0, 8'h01, 8'd2); wr(1, 8'h03, 8'd1); wr(2, 8'h80, 8'd3); wr(3, 8'h5C, 8'd0);
    expand();
    chk("oneshot_len", 32'(q.size()), 32'd24);
    launch();
    check_run("oneshot", 0, q.size());
    check_done("oneshot");

    bus.loop_en = 1'b1;
    launch();
    check_run("loop1", 0, q.size());
    check_run("loop2", 0, 10);
    bus.loop_en = 1'b0;
    check_run("loop2", 10, q.size());
    check_done("loop");

    launch();
    check_run("abort", 0, 4);
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
    chk("abort_led",  32'(bus.led),  32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    cyc();
    chk("abort_done2", 32'(bus.done), 32'd0);
    bus.start = 1'b1; bus.stop = 1'b1;
    cyc();
    bus.start = 1'b0; bus.stop = 1'b0;
    chk("ststop_busy", 32'(bus.busy), 32'd0);
    chk("ststop_done", 32'(bus.done), 32'd0);
    chk("ststop_led",  32'(bus.led),  32'd0);

    launch();
    check_run("wprot", 0, 2);
    bus.cfg_we = 1'b1; bus.cfg_addr = '0; bus.cfg_mask = 8'hFF; bus.cfg_dur = 8'd5;
    check_run("wprot", 2, 3);
    bus.cfg_we = 1'b0;
    check_run("wprot", 3, q.size());
    check_done("wprot");
    launch();
    check_run("wprot_rerun", 0, q.size());
    check_done("wprot_rerun");

    bus.cfg_we = 1'b1; bus.cfg_addr = '0; bus.cfg_mask = 8'hFF; bus.cfg_dur = 8'd5;
    bus.start = 1'b1;
    cyc();
    bus.cfg_we = 1'b0; bus.start = 1'b0;
    m_mask[0] = 8'hFF; m_dur[0] = 8'd5;
    expand();
    check_run("wrstart", 0, q.size());
    check_done("wrstart");

    for (int i = 0; i < STEPS; i++) wr(i, 8'($urandom), 8'd1);
    expand();
    chk("full_len", 32'(q.size()), 32'd32);
    launch();
    check_run("full", 0, q.size());
    check_done("full");

    repeat (4) begin
      n = $urandom_range(0, STEPS);
      for (int i = 0; i < STEPS; i++) begin
        if (i < n)       wr(i, 8'($urandom), 8'($urandom_range(1, 3)));
        else if (i == n) wr(i, 8'($urandom), 8'd0);
        else             wr(i, 8'($urandom), 8'($urandom_range(0, 3)));
      end
      expand();
      launch();
      check_run("rand", 0, q.size());
      check_done("rand");
    end

    for (int i = 0; i < STEPS; i++) wr(i, 8'($urandom), 8'($urandom_range(1, 3)));
    expand();
    launch();
    check_run("midrst", 0, 6);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midrst_led",  32'(bus.led),      32'd0);
    chk("midrst_busy", 32'(bus.busy),     32'd0);
    chk("midrst_done", 32'(bus.done),     32'd0);
    chk("midrst_idx",  32'(bus.step_idx), 32'd0);
    chk("midrst_tick", 32'(bus.tick),     32'd0);
    for (int i = 0; i < STEPS; i++) begin m_mask[i] = '0; m_dur[i] = '0; end
    expand();
    launch();
    check_done("cleared0");
    wr(0, 8'h5A, 8'd1);
    expand();
    chk("cleared1_len", 32'(q.size()), 32'd4);
    launch();
    check_run("cleared1", 0, q.size());
    check_done("cleared1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
